// File: rtl/spll_dac_spi_tx.sv
`default_nettype none
// ============================================================================
// spll_dac_spi_tx : 24-bit SPI frame transmitter for an AD5662-class DAC
// Revision: 1.0
// ============================================================================
module spll_dac_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int PAD_BITS   = 6
) (
  input  logic                  clk_sys,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dac_data,
  input  logic [1:0]            dac_pd,
  input  logic                  dac_load,
  output logic                  dac_sclk,
  output logic                  dac_sync_n,
  output logic                  dac_din,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            dropped_cnt
);

  localparam int FW    = PAD_BITS + 2 + DATA_WIDTH;
  localparam int WW    = DATA_WIDTH + 2;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FW + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FULL   = BIT_W'(FW);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [FW-2:0]     shreg;
  logic [WW-1:0]     pend_word;
  logic              pend_valid;

  logic [WW-1:0]     new_word;
  logic [FW-1:0]     start_frame;
  logic              hold_end;
  logic              start;

  // A load in the final HOLD cycle is newer than any pending word, so it wins.
  always_comb begin
    new_word    = {dac_pd, dac_data};
    start_frame = FW'(dac_load ? new_word : pend_word);
    hold_end    = (state == HOLD) && (div_cnt == '0);
    start       = ((state == IDLE) && dac_load) ||
                  (hold_end && (pend_valid || dac_load));
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      pend_word   <= '0;
      pend_valid  <= 1'b0;
      dac_sclk    <= 1'b0;
      dac_sync_n  <= 1'b1;
      dac_din     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dropped_cnt <= '0;
    end else begin
      done <= 1'b0;

      if (busy && dac_load) begin
        pend_word  <= new_word;
        pend_valid <= 1'b1;
        if (pend_valid && (dropped_cnt != 8'hFF))
          dropped_cnt <= dropped_cnt + 8'd1;
      end

      case (state)
        SETUP: begin
          if (div_cnt == '0) begin
            state    <= SHIFT;
            dac_sclk <= 1'b1;
            div_cnt  <= DIV_RELOAD;
            bit_cnt  <= BIT_FULL;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end

        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else if (dac_sclk) begin
            dac_sclk <= 1'b0;
            div_cnt  <= DIV_RELOAD;
          end else if (bit_cnt == BIT_W'(1)) begin
            state      <= HOLD;
            dac_sync_n <= 1'b1;
            dac_din    <= 1'b0;
            div_cnt    <= DIV_RELOAD;
            done       <= (CLK_DIV == 1);
          end else begin
            // Rising sclk edge: present the next bit.
            bit_cnt  <= bit_cnt - 1'b1;
            dac_sclk <= 1'b1;
            dac_din  <= shreg[FW-2];
            shreg    <= {shreg[FW-3:0], 1'b0};
            div_cnt  <= DIV_RELOAD;
          end
        end

        HOLD: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
            if (div_cnt == DIV_W'(1))
              done <= 1'b1;
          end else if (!start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: ;
      endcase

      if (start) begin
        state      <= SETUP;
        shreg      <= start_frame[FW-2:0];
        dac_din    <= start_frame[FW-1];
        dac_sync_n <= 1'b0;
        dac_sclk   <= 1'b0;
        busy       <= 1'b1;
        div_cnt    <= DIV_RELOAD;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spll_dac_spi_tx.md
Name: spll_dac_spi_tx

Overview:
Serial transmitter for the SoftPLL DAC interface. It accepts parallel 16-bit words with a one-cycle load strobe (the dac_dmtd_* and dac_out_* streams from the SoftPLL core) and shifts each word as a 24-bit SPI frame to an external AD5662-class DAC. One instance is used per DAC. Frame-in-flight updates are coalesced: the newest word wins and dropped words are counted.

Parameters:
CLK_DIV, 4, clk_sys cycles per SCLK half-period; legal range >= 1.
DATA_WIDTH, 16, DAC code width.
PAD_BITS, 6, zero bits sent before the power-down field; frame width FW = PAD_BITS + 2 + DATA_WIDTH = 24.

Ports:
clk_sys  in  1  system clock, 125 MHz.
rst  in  1  asynchronous reset, active-high.
dac_data  in  DATA_WIDTH  DAC code, sampled when dac_load=1.
dac_pd  in  2  power-down mode, sampled together with dac_data.
dac_load  in  1  one-cycle strobe requesting an update.
dac_sclk  out  1  SPI clock; idles low.
dac_sync_n  out  1  frame select, active-low; idles high.
dac_din  out  1  serial data, MSB first.
busy  out  1  frame in progress (SETUP, SHIFT or HOLD).
done  out  1  one-cycle pulse in the last HOLD cycle of every frame.
dropped_cnt  out  8  count of overwritten pending words; saturates at 255.

Behaviour:
- Reset (async, rst=1): state IDLE, dac_sclk=0, dac_sync_n=1, dac_din=0, busy=0, done=0, dropped_cnt=0, pending cleared.
- An abort mid-frame raises sync_n immediately. The DAC discards the partial frame.
- Frame word: {PAD_BITS zeros, dac_pd, dac_data}, latched into the shift register when the frame starts.
- FSM states: IDLE, SETUP, SHIFT, HOLD. A down-counter div_cnt sets the timing and bit_cnt counts FW..1.
- IDLE: if dac_load=1 at edge N, enter SETUP at N+1.
  - sync_n=0, sclk=0, din=frame MSB, busy=1 from cycle N+1.
- SETUP: lasts CLK_DIV cycles, then SHIFT.
- SHIFT: each bit lasts 2*CLK_DIV cycles.
  - First CLK_DIV cycles: sclk=1. Next CLK_DIV cycles: sclk=0.
  - The DAC samples din on the falling edge.
  - din is updated to the next bit on each rising sclk edge, except the first bit, which is already valid from SETUP.
  - After FW bits, enter HOLD.
- HOLD: sync_n=1, sclk=0, din=0 for CLK_DIV cycles. done=1 in the final HOLD cycle.
  - After HOLD: if pending is valid, load it, clear pending and enter SETUP on the next cycle. Otherwise enter IDLE with busy=0.
- Default timing (CLK_DIV=4):
  - sync_n low for 4+192 = 196 cycles.
  - Frame length 200 cycles; busy high for 200 cycles.
- Pending buffer (one entry) when dac_load=1 while busy=1, including the final HOLD cycle:
  - If pending is empty: capture {dac_pd, dac_data}, pending valid.
  - If pending is valid: overwrite it, and dropped_cnt += 1 (saturates at 255).
- The word currently shifting is never altered.
- dac_load in the same cycle the FSM enters IDLE counts as an IDLE-state load (busy is already 0).
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset release, then load 0xA5C3 with pd=00 at cycle 10 (CLK_DIV=4): sync_n falls at cycle 11 and rises at 207; done at 210; busy 11..210. The falling-edge-sampled bitstream equals 0x00A5C3 MSB first, with exactly 24 falling sclk edges.
- Load 0x1234, then 0xFFFF 50 cycles later: the second frame's SETUP starts the cycle after the first frame's done; the decoded frames are 0x001234 then 0x00FFFF; dropped_cnt=0.
- During one frame, load 0x0001, 0x0002, 0x0003: only 0x0003 is sent next; dropped_cnt=2. Then 300 extra overwrite loads: dropped_cnt saturates at 255.
- Load issued exactly in the final HOLD cycle: accepted as pending, and the next frame starts with no IDLE cycle.
- Assert rst at cycle 100 of a frame: sync_n=1 and sclk=0 asynchronously, pending is cleared, and there is no done pulse. A new load after release produces a clean full frame.
- CLK_DIV=1 with pd=11, data=0x8000: frame length 50 cycles; decoded word is 0x038000.
